// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
//   state_t   : control FSM encoding (IDLE, CALC, DONE)
//   cnt_width : width of the step counter for a W-bit operand, at least 1 bit
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to hold W-1, so clog2(W) bits are enough.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage : seq_mult_pkg

// File: rtl/seq_mult_dp.sv
// Datapath of the sequential shift-and-add multiplier.
// Converts the operands to magnitudes on load, accumulates one partial
// product per step into a W+1-bit high accumulator, shifts {hi, Q} right,
// and presents the sign-corrected 2W-bit product combinationally.
//   clk, rst_n     : clock, asynchronous active-low reset
//   load_i         : capture a_i/b_i/signed_mode_i and clear the accumulator
//   step_i         : perform one add-and-shift iteration
//   signed_mode_i  : 1 = operands are two's complement, 0 = unsigned
//   a_i, b_i       : multiplicand, multiplier (W bits)
//   result_o       : signed/unsigned product of the finished iterations (2W bits)
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           signed_mode_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] result_o
);

  logic [W-1:0]   m_q, m_d;    // multiplicand magnitude
  logic [W-1:0]   q_q, q_d;    // multiplier magnitude, low half of the product
  logic [W:0]     hi_q, hi_d;  // high accumulator, one extra bit for the carry
  logic           neg_q, neg_d;

  logic           sign_a, sign_b;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     sum;
  logic [W:0]     hi_acc;
  logic [2*W-1:0] mag_prod;

  // In unsigned mode the top bit is just a weight, never a sign.
  assign sign_a = signed_mode_i & a_i[W-1];
  assign sign_b = signed_mode_i & b_i[W-1];

  // |-2^(W-1)| negates to itself, which read as unsigned is the right magnitude.
  assign mag_a = sign_a ? (~a_i + W'(1)) : a_i;
  assign mag_b = sign_b ? (~b_i + W'(1)) : b_i;

  assign sum    = hi_q + {1'b0, m_q};
  assign hi_acc = q_q[0] ? sum : hi_q;

  assign mag_prod = {hi_q[W-1:0], q_q};
  assign result_o = neg_q ? (~mag_prod + (2*W)'(1)) : mag_prod;

  // NOTE: every variable assigned in an always_comb gets a default first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    m_d   = m_q;
    q_d   = q_q;
    hi_d  = hi_q;
    neg_d = neg_q;
    if (load_i) begin
      m_d   = mag_a;
      q_d   = mag_b;
      hi_d  = '0;
      neg_d = sign_a ^ sign_b;
    end else if (step_i) begin
      // Shift {hi_acc, Q} right by one with a zero entering the top.
      hi_d = {1'b0, hi_acc[W:1]};
      q_d  = {hi_acc[0], q_q[W-1:1]};
    end
  end

  // NOTE: these are plain flops, not a memory, so all of them get a reset
  // value; that keeps the datapath deterministic straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      q_q   <= '0;
      hi_q  <= '0;
      neg_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      q_q   <= q_d;
      hi_q  <= hi_d;
      neg_q <= neg_d;
    end
  end

endmodule : seq_mult_dp

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-and-add multiplier, one partial product per clock.
// Holds the control FSM, the step counter and the registered handshake
// outputs; the arithmetic lives in seq_mult_dp.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, accepted only in IDLE
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned (captured with start)
//   a, b         : multiplicand, multiplier (W bits, captured with start)
//   busy         : high from the cycle after an accepted start until done falls
//   done         : one-cycle pulse, product valid
//   product      : 2W-bit result, held until the next result is written
module seq_mult_shift_add
  import seq_mult_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = cnt_width(W);

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2*W-1:0] product_q, product_d;

  logic           load;
  logic           step;
  logic [2*W-1:0] result;

  seq_mult_dp #(
    .W (W)
  ) u_dp (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load),
    .step_i        (step),
    .signed_mode_i (signed_mode),
    .a_i           (a),
    .b_i           (b),
    .result_o      (result)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    load      = 1'b0;
    step      = 1'b0;

    // busy drops on the same edge that ends the done pulse; a start accepted
    // on that edge re-raises it below.
    if (done_q) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          load    = 1'b1;
          count_d = CW'(W - 1);
          busy_d  = 1'b1;
        end
      end
      CALC: begin
        step = 1'b1;
        if (count_q == '0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      DONE: begin
        product_d = result;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule : seq_mult_shift_add

// File: tb/tb_seq_mult_shift_add.sv
// Directed testbench for seq_mult_shift_add with W=4.
module tb_seq_mult_shift_add;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  seq_mult_shift_add #(
    .W (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Drive a request so that it is sampled on the next rising edge; returns
  // just after that edge with start low and the operands scrambled.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm);
    @(negedge clk);
    a           = av;
    b           = bv;
    signed_mode = sm;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    a           = ~av;
    b           = ~bv;
    signed_mode = ~sm;
  endtask

  // Wait (bounded) for done; lat is the edge count after the start edge,
  // -1 when the bound expires.
  task automatic wait_done(output int lat, output logic [2*W-1:0] prod, output int at_cycle);
    lat      = -1;
    prod     = 'x;
    at_cycle = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat      = i;
        prod     = product;
        at_cycle = cycle;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b product=%h, want 0 0 00", busy, done, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_max();
    int lat, at;
    logic [2*W-1:0] p;
    issue(4'hF, 4'hF, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: busy=%b, want 1", busy);
    end
    wait_done(lat, p, at);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL u15x15_latency: got %0d, want 5", lat);
    end
    checks++;
    if (p !== 8'hE1) begin
      errors++;
      $display("FAIL u15x15_product: got %h, want e1", p);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || product !== 8'hE1) begin
      errors++;
      $display("FAIL done_pulse_hold: done=%b product=%h, want 0 e1", done, product);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_signed_min();
    int lat, at;
    logic [2*W-1:0] p;
    issue(4'h8, 4'h8, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (product !== 8'hE1) begin
      errors++;
      $display("FAIL product_stable_in_calc: got %h, want e1", product);
    end
    wait_done(lat, p, at);
    checks++;
    if (lat !== 4 || p !== 8'h40) begin
      errors++;
      $display("FAIL s_min_x_min: lat=%0d product=%h, want 4 (after extra wait) 40", lat, p);
    end
  endtask

  task automatic test_signed_mixed();
    int lat, at;
    logic [2*W-1:0] p;
    issue(4'h7, 4'hD, 1'b1);
    wait_done(lat, p, at);
    checks++;
    if (lat !== 5 || p !== 8'hEB) begin
      errors++;
      $display("FAIL s_7x_neg3: lat=%0d product=%h, want 5 eb", lat, p);
    end
    issue(4'h7, 4'hD, 1'b0);
    wait_done(lat, p, at);
    checks++;
    if (lat !== 5 || p !== 8'h5B) begin
      errors++;
      $display("FAIL u_7x13: lat=%0d product=%h, want 5 5b", lat, p);
    end
  endtask

  task automatic test_start_while_busy();
    int pulses;
    int first_lat;
    logic [2*W-1:0] p;
    issue(4'h2, 4'h3, 1'b0);
    @(negedge clk);
    a           = 4'h1;
    b           = 4'h1;
    signed_mode = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    pulses    = 0;
    first_lat = -1;
    p         = 'x;
    // Already one edge past the start edge; watch 14 more.
    for (int i = 2; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (first_lat < 0) begin
          first_lat = i;
          p         = product;
        end
      end
    end
    checks++;
    if (pulses !== 1 || first_lat !== 5) begin
      errors++;
      $display("FAIL busy_start_ignored: pulses=%0d lat=%0d, want 1 5", pulses, first_lat);
    end
    checks++;
    if (p !== 8'h06) begin
      errors++;
      $display("FAIL busy_first_result: got %h, want 06", p);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, at, pulses;
    logic [2*W-1:0] p;
    issue(4'hF, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b product=%h, want 0 0 00", busy, done, product);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL no_done_after_reset: pulses=%0d, want 0", pulses);
    end
    issue(4'h3, 4'h5, 1'b0);
    wait_done(lat, p, at);
    checks++;
    if (lat !== 5 || p !== 8'h0F) begin
      errors++;
      $display("FAIL after_reset_3x5: lat=%0d product=%h, want 5 0f", lat, p);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, at1, at2;
    logic [2*W-1:0] p1, p2;
    issue(4'h7, 4'h7, 1'b0);
    wait_done(lat1, p1, at1);
    checks++;
    if (p1 !== 8'h31) begin
      errors++;
      $display("FAIL b2b_preload_7x7: got %h, want 31", p1);
    end
    issue(4'h0, 4'h9, 1'b0);
    wait_done(lat1, p1, at1);
    // Next request is sampled on the first edge after the done cycle.
    issue(4'h9, 4'h0, 1'b0);
    wait_done(lat2, p2, at2);
    checks++;
    if (lat1 !== 5 || p1 !== 8'h00) begin
      errors++;
      $display("FAIL b2b_0x9: lat=%0d product=%h, want 5 00", lat1, p1);
    end
    checks++;
    if (lat2 !== 5 || p2 !== 8'h00) begin
      errors++;
      $display("FAIL b2b_9x0: lat=%0d product=%h, want 5 00", lat2, p2);
    end
    checks++;
    if (at1 < 0 || at2 < 0 || (at2 - at1) !== W + 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles, want %0d", at2 - at1, W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_min();
    test_signed_mixed();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_mult_shift_add

// File: doc/seq_mult_shift_add.md
# seq_mult_shift_add

Parametrised sequential shift-and-add multiplier with a start/busy/done handshake and a run-time signed/unsigned mode. It generalises the team's fixed 4x4 combinational array multiplier to any operand width W. It trades area for latency: one partial product is accumulated per clock. It sits behind the same pin-level wrappers as the array multiplier and suits designs where a full W×W array is too large.

## Interface
Parameters:
- W, default 4: operand width in bits; legal range 2..16. The product is 2W bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- a  in  W  multiplicand; captured with start.
- b  in  W  multiplier; captured with start.
- busy  out  1  high while a multiplication is in progress (CALC or DONE).
- done  out  1  one-cycle pulse when product is valid.
- product  out  2W  result; held stable from done until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC when start=1.
  - Latch sign_a and sign_b; these are a[W-1]/b[W-1] when signed_mode=1, else 0.
  - Latch M = |a| and Q = |b| as W-bit unsigned values. Magnitude of -2^(W-1) is 2^(W-1), which still fits W bits.
  - Latch neg = sign_a ^ sign_b.
  - Clear hi accumulator (W+1 bits).
  - Load count = W-1.
- CALC, each cycle:
  - If Q[0], then hi = hi + M (W+1-bit add, carry kept).
  - Then shift {hi, Q} right by 1, with 0 entering the MSB.
  - When count = 0, go to DONE; otherwise decrement count.
- DONE:
  - Write product = neg ? -{hi[W-1:0], Q} : {hi[W-1:0], Q}. The negation is 2W-bit two's-complement.
  - Assert done for this cycle only.
  - Return to IDLE next cycle.
- Range: the signed result always fits 2W bits; the maximum is (-2^(W-1))^2 = 2^(2W-2). The unsigned maximum is (2^W-1)^2.
- start in CALC or DONE is ignored. Inputs a, b and signed_mode are don't-care outside the IDLE start cycle.
- product is not modified by CALC; it changes only in DONE.
- Asserting rst_n low at any time:
  - state = IDLE; busy = 0, done = 0, product = 0.
  - The in-flight operation is discarded, with no done pulse.

## Timing
- Reset values: busy 0, done 0, product 0, all internal registers 0.
- Start-to-done latency:
  - start is sampled high in IDLE at edge 0.
  - CALC occupies edges 1..W.
  - done=1 and product valid during the cycle after edge W+1.
  - Total latency W+1 clocks.
- busy rises the cycle after start is accepted and falls together with done.
- Throughput: one result per W+2 cycles. The earliest next start is sampled in IDLE, which is the cycle after done.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package seq_mult_pkg:
  - state_t enum {IDLE, CALC, DONE}.
  - localparam function giving the count width, clog2(W).
- Sub-module seq_mult_dp, the datapath:
  - Magnitude conversion, the W+1-bit adder, the {hi,Q} shift register, and the final conditional negation.
- The top level holds the FSM, the counter and the handshake registers.

## Test plan
All scenarios use W=4.
- Unsigned 15×15: a=4'hF, b=4'hF, signed_mode=0 -> done at start+5, product=8'hE1 (225).
- Signed min×min: a=4'h8, b=4'h8, signed_mode=1 -> product=8'h40 (+64).
- Signed mixed: a=4'h7, b=4'hD (-3), signed_mode=1 -> product=8'hEB (-21). The same operands with signed_mode=0 -> 8'h5B (91).
- Start while busy: a second start with a=1, b=1 one cycle after the first start -> ignored. The first result is delivered, with exactly one done pulse.
- Reset mid-operation: rst_n low in the 2nd CALC cycle -> busy, done and product are 0 immediately. There is no done pulse afterwards, and a new start=3×5 yields 8'h0F.
- Zero and back-to-back: 0×9 then 9×0, with start asserted the cycle after each done -> product=0 both times, done pulses spaced W+2 cycles apart.
